// File: rtl/blk_76a81f.sv
// Debug-master response adapter: tags beats with a fixed channel, drops orphan beats, 2-entry skid buffer.
// Latency 1 cycle into an empty buffer; in_ready depends only on buffer occupancy, never on out_ready.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module blk_76a81f #(
    parameter int DATA_W      = 8,
    parameter int CHANNEL_W   = 8,
    parameter int OUT_CHANNEL = 0,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [CHANNEL_W-1:0] out_channel,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 framing_err,
    input  logic                 clear_stats
);
    typedef enum logic {IDLE, IN_PKT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        count;
    logic              accept;
    logic              push;
    logic              err_set;
    logic              pop;
    logic [DATA_W+1:0] head;

    assign in_ready = reset_n && (count != 2'd2);
    assign accept   = in_valid && in_ready;

    // Orphan beats in IDLE are consumed but never buffered.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        err_set   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_startofpacket) begin
                        push = 1'b1;
                        if (!in_endofpacket) state_nxt = IN_PKT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                IN_PKT: begin
                    push    = 1'b1;
                    err_set = in_startofpacket;
                    if (in_endofpacket) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    fifo #(.W(DATA_W + 2), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat ({in_data, in_startofpacket, in_endofpacket}),
        .pop      (pop),
        .pop_dat  (head),
        .count    (count)
    );

    assign out_valid   = (count != 2'd0);
    assign pop         = out_valid && out_ready;
    assign out_channel = CHANNEL_W'(OUT_CHANNEL);
    assign {out_data, out_startofpacket, out_endofpacket} = head;

    // clear_stats has priority over a same-cycle increment or error.
    always_ff @(posedge clk) begin
        if (!reset_n || clear_stats) begin
            pkt_count   <= '0;
            framing_err <= 1'b0;
        end else begin
            if (pop && out_endofpacket && pkt_count != CNT_MAX)
                pkt_count <= pkt_count + CNT_W'(1);
            if (err_set)
                framing_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_blk_76a81f.sv
// Bench for blk_76a81f: directed scenarios plus random traffic against a queue-based packet model.
module tb_blk_76a81f;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_ready;
    logic             iv;
    logic [7:0]       idat;
    logic             isop;
    logic             ieop;
    logic             ordy;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [7:0]       out_channel;
    logic             out_sop;
    logic             out_eop;
    logic [CNT_W-1:0] pkt_count;
    logic             framing_err;
    logic             clr;

    always #5 clk = ~clk;

    blk_76a81f #(.DATA_W(8), .CHANNEL_W(8), .OUT_CHANNEL(0), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset_n           (rst_n),
        .in_ready          (in_ready),
        .in_valid          (iv),
        .in_data           (idat),
        .in_startofpacket  (isop),
        .in_endofpacket    (ieop),
        .out_ready         (ordy),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .pkt_count         (pkt_count),
        .framing_err       (framing_err),
        .clear_stats       (clr)
    );

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    beat_t q[$];
    bit    in_pkt   = 0;
    int    m_cnt    = 0;
    bit    m_err    = 0;
    bit    last_acc = 0;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check the DUT against the model, then advance the model across the next rising edge.
    task automatic cycle();
        bit acc, pop, popeop, push, err;
        @(negedge clk);
        chk("in_ready", in_ready, 32'(rst_n && q.size() < 2));
        chk("out_valid", out_valid, 32'(q.size() != 0));
        chk("out_channel", out_channel, 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_sop", out_sop, q[0].s);
            chk("out_eop", out_eop, q[0].e);
        end
        chk("pkt_count", pkt_count, m_cnt);
        chk("framing_err", framing_err, m_err);
        if (!rst_n) begin
            q.delete();
            in_pkt = 0; m_cnt = 0; m_err = 0; last_acc = 0;
        end else begin
            acc    = iv && q.size() < 2;
            pop    = ordy && q.size() != 0;
            popeop = pop && q[0].e;
            push   = 0;
            err    = 0;
            if (acc) begin
                if (!in_pkt && !isop) err = 1;
                else begin
                    push = 1;
                    if (in_pkt && isop) err = 1;
                    in_pkt = !ieop;
                end
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{idat, isop, ieop});
            if (clr) begin
                m_cnt = 0; m_err = 0;
            end else begin
                if (popeop && m_cnt != CNT_MAX) m_cnt++;
                if (err) m_err = 1;
            end
            last_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iv = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Present a beat and hold it until the model says it was taken.
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        iv = 1; idat = d; isop = s; ieop = e;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 64);
        chk("send_accepted", last_acc, 1);
        iv = 0;
    endtask

    initial begin
        rst_n = 0; iv = 0; idat = 0; isop = 0; ieop = 0; ordy = 1; clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_eop", out_eop, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_framing_err", framing_err, 0);

        // 3-beat packet with out_ready high
        rst_n = 1;
        send(8'hA0, 1, 0);
        send(8'hA1, 0, 0);
        send(8'hA2, 0, 1);
        idle(2);
        chk("pkt3_count", pkt_count, 1);
        chk("pkt3_err", framing_err, 0);

        // backpressure: only two beats fit
        ordy = 0;
        send(8'hB0, 1, 0);
        send(8'hB1, 0, 0);
        iv = 1; idat = 8'hB2; isop = 0; ieop = 0;
        cycle();
        cycle();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_data", out_data, 8'hB0);
        ordy = 1;
        send(8'hB2, 0, 0);
        send(8'hB3, 0, 1);
        idle(3);
        chk("bp_count", pkt_count, 2);

        // orphan beat in IDLE
        send(8'h55, 0, 0);
        idle(2);
        chk("orphan_err", framing_err, 1);
        chk("orphan_count", pkt_count, 2);
        chk("orphan_no_out", out_valid, 0);

        // back-to-back single-beat packets
        for (int i = 0; i < 3; i++) send(8'h7E, 1, 1);
        idle(2);
        chk("single_count", pkt_count, 5);

        // clear_stats coinciding with an EOP pop, second beat still buffered
        ordy = 0;
        send(8'hD0, 1, 1);
        send(8'hE0, 1, 0);
        ordy = 1; clr = 1;
        cycle();
        clr = 0; ordy = 0;
        chk("clr_count", pkt_count, 0);
        chk("clr_err", framing_err, 0);
        chk("clr_fifo_valid", out_valid, 1);
        chk("clr_fifo_data", out_data, 8'hE0);
        ordy = 1;
        send(8'hE1, 0, 1);
        idle(2);
        chk("clr_after_count", pkt_count, 1);

        // reset mid-packet with two beats buffered
        ordy = 0;
        send(8'hF0, 1, 0);
        send(8'hF1, 0, 0);
        rst_n = 0;
        cycle();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst_n = 1; ordy = 1;
        send(8'h66, 0, 1);
        idle(2);
        chk("midrst_err", framing_err, 1);
        chk("midrst_no_out", out_valid, 0);
        chk("midrst_count", pkt_count, 0);

        // saturation of the packet counter
        clr = 1;
        cycle();
        clr = 0;
        for (int i = 0; i < CNT_MAX + 5; i++) send(8'(i), 1, 1);
        idle(2);
        chk("sat_count", pkt_count, CNT_MAX);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            iv    = ($urandom_range(0, 3) != 0);
            idat  = 8'($urandom);
            isop  = ($urandom_range(0, 2) == 0);
            ieop  = ($urandom_range(0, 2) == 0);
            ordy  = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1; clr = 0; ordy = 1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
